// File: rtl/mem_bank_be.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bank_be
//  Brief    : Simple-dual-port RAM with byte enables, 1/2-cycle read latency,
//             selectable read-during-write behaviour and a hardware clear sweep.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_bank_be #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 5,
  parameter int MEM_SIZE     = 32,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_req,
  input  logic                    write_en,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   write_address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    read_en,
  input  logic [ADDR_WIDTH-1:0]   read_address,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  output logic                    init_done
);

  localparam int                    c_nb    = DATA_WIDTH / 8;
  localparam int                    c_idx_w = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [ADDR_WIDTH:0]   c_size  = (ADDR_WIDTH + 1)'(MEM_SIZE);
  localparam logic [ADDR_WIDTH-1:0] c_last  = ADDR_WIDTH'(MEM_SIZE - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;

  logic [DATA_WIDTH-1:0] r_mem [MEM_SIZE];

  logic                  w_ready;
  logic                  w_clearing;
  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [c_idx_w-1:0]    w_widx;
  logic [c_idx_w-1:0]    w_ridx;
  logic [c_idx_w-1:0]    w_cidx;
  logic [DATA_WIDTH-1:0] w_rd_word;

  logic                  r_s1_vld;
  logic [DATA_WIDTH-1:0] r_s1_data;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_cnt == c_last) begin
          w_state_nxt   = ST_READY;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
        end
      end
      ST_READY: begin
        if (clear_req) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  assign w_ready    = (r_state == ST_READY);
  assign w_clearing = (r_state == ST_CLEAR);
  assign init_done  = w_ready;

  // ------------------------------------------------------- access decode
  assign w_wr_in_range = ({1'b0, write_address} < c_size);
  assign w_rd_in_range = ({1'b0, read_address} < c_size);
  assign w_wr_acc      = w_ready & write_en & w_wr_in_range;
  assign w_rd_acc      = w_ready & read_en;
  assign w_widx        = write_address[c_idx_w-1:0];
  assign w_ridx        = read_address[c_idx_w-1:0];
  assign w_cidx        = r_clr_cnt[c_idx_w-1:0];

  // The array itself has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clearing) begin
        r_mem[w_cidx] <= '0;
      end else if (w_wr_acc) begin
        for (int i = 0; i < c_nb; i++) begin
          if (byte_en[i]) begin
            r_mem[w_widx][8*i +: 8] <= data_in[8*i +: 8];
          end
        end
      end
    end
  end

  // Same-address bypass forwards the enabled write bytes when RDW_MODE=1.
  always_comb begin
    w_rd_word = w_rd_in_range ? r_mem[w_ridx] : '0;
    if (RDW_MODE == 1 && w_wr_acc && (write_address == read_address)) begin
      for (int i = 0; i < c_nb; i++) begin
        if (byte_en[i]) begin
          w_rd_word[8*i +: 8] = data_in[8*i +: 8];
        end
      end
    end
  end

  // ------------------------------------------------------- read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld  <= 1'b0;
      r_s1_data <= '0;
    end else begin
      r_s1_vld <= w_rd_acc;
      if (w_rd_acc) begin
        r_s1_data <= w_rd_word;
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  r_s2_vld;
      logic [DATA_WIDTH-1:0] r_s2_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2_vld  <= 1'b0;
          r_s2_data <= '0;
        end else begin
          r_s2_vld <= r_s1_vld;
          if (r_s1_vld) begin
            r_s2_data <= r_s1_data;
          end
        end
      end

      assign data_out = r_s2_data;
      assign rd_valid = r_s2_vld;
    end else begin : g_lat1
      assign data_out = r_s1_data;
      assign rd_valid = r_s1_vld;
    end
  endgenerate

endmodule
`default_nettype wire
